vc_crossbar: RTL and testbench

VC_CROSSBAR -- requirements
Module: vc_crossbar

---
 rtl/vc_crossbar_pkg.sv | 23 ++
 rtl/vc_crossbar_port.sv | 85 ++++++++
 rtl/vc_crossbar.sv | 107 ++++++++++
 tb/tb_vc_crossbar.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_crossbar_pkg.sv
// Shared switch definitions: flit type, output-port state encoding and width helpers.
package vc_crossbar_pkg;

    localparam int FLIT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic {
        PORT_IDLE = 1'b0,
        PORT_HOLD = 1'b1
    } port_state_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_crossbar_port.sv
// One crossbar output: IDLE/HOLD state, output register, per-VC credits and round-robin pointer.
module vc_crossbar_port
    import vc_crossbar_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int MIN_CREDIT  = 1,
    parameter int CREDIT_STEP = 1,
    localparam int VC_W = idx_w(NUM_VCS),
    localparam int CW   = credit_w(BUFFER_SIZE)
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         issue,
    input  logic [VC_W-1:0]              issue_vc,
    input  flit_t                        issue_flit,
    input  logic                         out_ready,
    input  logic [NUM_VCS-1:0]           credit_return,
    output logic                         accept,
    output logic [NUM_VCS-1:0]           credit_ok,
    output logic [VC_W-1:0]              rr_ptr,
    output port_state_t                  state,
    output flit_t                        out_flit,
    output logic [VC_W-1:0]              out_vc,
    output logic [NUM_VCS-1:0][CW-1:0]   credits
);

    port_state_t                state_d;
    logic [VC_W-1:0]            ptr_d;
    logic [NUM_VCS-1:0][CW-1:0] credits_d;
    int                         c;

    // Valid/ready: a held flit leaves when out_valid && out_ready at a rising edge;
    // the port may take a new flit in that same cycle (or any cycle it is IDLE).
    always_comb begin
        accept  = (state == PORT_IDLE) || out_ready;
        state_d = state;
        if (issue) begin
            state_d = PORT_HOLD;
        end else if (accept) begin
            state_d = PORT_IDLE;
        end
    end

    // rr_ptr names the VC searched first; it moves just past the VC last issued.
    always_comb begin
        ptr_d = rr_ptr;
        if (issue) begin
            ptr_d = (int'(issue_vc) == NUM_VCS - 1) ? '0 : issue_vc + 1'b1;
        end
    end

    always_comb begin
        c         = 0;
        credits_d = credits;
        credit_ok = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            c = int'(credits[v]);
            if (issue && int'(issue_vc) == v) c = c - 1;
            if (credit_return[v]) c = c + CREDIT_STEP;
            if (c > BUFFER_SIZE) c = BUFFER_SIZE;
            credits_d[v] = CW'(c);
            credit_ok[v] = int'(credits[v]) >= MIN_CREDIT;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= PORT_IDLE;
            rr_ptr   <= '0;
            out_flit <= '0;
            out_vc   <= '0;
            credits  <= {NUM_VCS{CW'(BUFFER_SIZE)}};
        end else begin
            state   <= state_d;
            rr_ptr  <= ptr_d;
            credits <= credits_d;
            if (issue) begin
                out_flit <= issue_flit;
                out_vc   <= issue_vc;
            end
        end
    end

endmodule

// File: rtl/vc_crossbar.sv
// Virtual-channel crossbar: per-output VC arbitration with input-conflict resolution in index order.
module vc_crossbar
    import vc_crossbar_pkg::*;
#(
    parameter int NUM_IN      = 5,
    parameter int NUM_OUT     = 5,
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int MIN_CREDIT  = 1,
    parameter int CREDIT_STEP = 1,
    localparam int SEL_W = idx_w(NUM_IN),
    localparam int VC_W  = idx_w(NUM_VCS),
    localparam int CW    = credit_w(BUFFER_SIZE)
) (
    input  logic                                      clk,
    input  logic                                      n_rst,
    input  flit_t [NUM_IN-1:0]                        in_flit,
    input  logic  [NUM_IN-1:0]                        in_empty,
    output logic  [NUM_IN-1:0]                        in_pop,
    input  logic  [NUM_OUT-1:0][NUM_VCS-1:0][SEL_W-1:0] sel,
    input  logic  [NUM_OUT-1:0][NUM_VCS-1:0]          enable,
    output flit_t [NUM_OUT-1:0]                       out_flit,
    output logic  [NUM_OUT-1:0]                       out_valid,
    output logic  [NUM_OUT-1:0][VC_W-1:0]             out_vc,
    input  logic  [NUM_OUT-1:0]                       out_ready,
    input  logic  [NUM_OUT-1:0][NUM_VCS-1:0]          credit_return,
    output logic  [NUM_OUT-1:0][NUM_VCS-1:0][CW-1:0]  credits
);

    logic  [NUM_OUT-1:0]               accept;
    logic  [NUM_OUT-1:0]               issue;
    logic  [NUM_OUT-1:0][VC_W-1:0]     issue_vc;
    logic  [NUM_OUT-1:0][VC_W-1:0]     rr_ptr;
    logic  [NUM_OUT-1:0][NUM_VCS-1:0]  credit_ok;
    flit_t [NUM_OUT-1:0]               issue_flit;
    port_state_t                       port_state [NUM_OUT];

    logic [NUM_IN-1:0]  claimed;
    logic [NUM_VCS-1:0] elig;
    int                 s;
    int                 pv;
    int                 src;

    // Outputs are visited in index order; an input taken by a lower output is
    // masked out for every higher output in the same cycle.
    always_comb begin
        claimed    = '0;
        in_pop     = '0;
        issue      = '0;
        issue_vc   = '0;
        issue_flit = '0;
        elig       = '0;
        s          = 0;
        pv         = 0;
        src        = 0;
        for (int o = 0; o < NUM_OUT; o++) begin
            elig = '0;
            src  = 0;
            for (int v = 0; v < NUM_VCS; v++) begin
                s = int'(sel[o][v]);
                if (enable[o][v] && s < NUM_IN && credit_ok[o][v]) begin
                    if (!in_empty[s] && !claimed[s]) elig[v] = 1'b1;
                end
            end
            for (int k = 0; k < NUM_VCS; k++) begin
                pv = (int'(rr_ptr[o]) + k) % NUM_VCS;
                if (accept[o] && !issue[o] && elig[pv]) begin
                    issue[o]    = 1'b1;
                    issue_vc[o] = VC_W'(pv);
                    src         = int'(sel[o][pv]);
                end
            end
            if (issue[o]) begin
                claimed[src]  = 1'b1;
                in_pop[src]   = n_rst;
                issue_flit[o] = in_flit[src];
            end
        end
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_port
        vc_crossbar_port #(
            .NUM_VCS     (NUM_VCS),
            .BUFFER_SIZE (BUFFER_SIZE),
            .MIN_CREDIT  (MIN_CREDIT),
            .CREDIT_STEP (CREDIT_STEP)
        ) u_port (
            .clk           (clk),
            .n_rst         (n_rst),
            .issue         (issue[o]),
            .issue_vc      (issue_vc[o]),
            .issue_flit    (issue_flit[o]),
            .out_ready     (out_ready[o]),
            .credit_return (credit_return[o]),
            .accept        (accept[o]),
            .credit_ok     (credit_ok[o]),
            .rr_ptr        (rr_ptr[o]),
            .state         (port_state[o]),
            .out_flit      (out_flit[o]),
            .out_vc        (out_vc[o]),
            .credits       (credits[o])
        );

        assign out_valid[o] = (port_state[o] == PORT_HOLD);
    end

endmodule

// File: tb/tb_vc_crossbar.sv
// Directed bench for vc_crossbar: expected flits queued at stimulus time, checked by a monitor.
module tb_vc_crossbar;
    import vc_crossbar_pkg::*;

    localparam int NI = 5;
    localparam int NO = 5;
    localparam int NV = 2;
    localparam int BS = 8;
    localparam int SW = idx_w(NI);
    localparam int VW = idx_w(NV);
    localparam int CW = credit_w(BS);
    localparam int EW = 3 + VW + FLIT_W;

    logic clk = 1'b0;
    logic n_rst;

    flit_t [NI-1:0]                 in_flit;
    logic  [NI-1:0]                 in_empty;
    logic  [NI-1:0]                 in_pop;
    logic  [NO-1:0][NV-1:0][SW-1:0] sel;
    logic  [NO-1:0][NV-1:0]         enable;
    flit_t [NO-1:0]                 out_flit;
    logic  [NO-1:0]                 out_valid;
    logic  [NO-1:0][VW-1:0]         out_vc;
    logic  [NO-1:0]                 out_ready;
    logic  [NO-1:0][NV-1:0]         credit_return;
    logic  [NO-1:0][NV-1:0][CW-1:0] credits;
    logic  [NO-1:0][NV-1:0][CW-1:0] full_cr;

    int seq [NI];
    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    vc_crossbar #(
        .NUM_IN(NI), .NUM_OUT(NO), .NUM_VCS(NV), .BUFFER_SIZE(BS),
        .MIN_CREDIT(1), .CREDIT_STEP(1)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .in_flit       (in_flit),
        .in_empty      (in_empty),
        .in_pop        (in_pop),
        .sel           (sel),
        .enable        (enable),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .out_vc        (out_vc),
        .out_ready     (out_ready),
        .credit_return (credit_return),
        .credits       (credits)
    );

    // ---- clock / input-buffer model ----
    always #5 clk = ~clk;

    // Each input buffer presents {input index, running sequence number}.
    always_comb begin
        for (int i = 0; i < NI; i++) in_flit[i] = {8'(i), 24'(seq[i])};
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) if (in_pop[i]) seq[i] <= seq[i] + 1;
    end

    // ---- driver / check tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int o, input int vc, input logic [31:0] flit);
        exp_q.push_back({3'(o), VW'(vc), flit});
    endtask

    // ---- scoreboard monitor ----
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            for (int o = 0; o < NO; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_flit: out%0d vc %0d flit %0h, expected none",
                                 o, out_vc[o], out_flit[o]);
                    end else begin
                        check("scoreboard", {3'(o), out_vc[o], out_flit[o]}, exp_q.pop_front());
                    end
                end
            end
            check("pop_on_empty", in_pop & in_empty, 0);
        end
    end

    // ---- directed stimulus ----
    initial begin
        for (int o = 0; o < NO; o++)
            for (int v = 0; v < NV; v++) full_cr[o][v] = CW'(BS);
        n_rst         = 1'b1;
        in_empty      = '0;
        sel           = '0;
        enable        = '0;
        enable[0][0]  = 1'b1;
        out_ready     = '1;
        credit_return = '0;
        #1 n_rst = 1'b0;
        #2;
        check("rst_in_pop", in_pop, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_credits", credits, full_cr);
        enable   = '0;
        in_empty = '1;
        at_neg();
        n_rst = 1'b1;
        step();
        at_neg();
        check("post_rst_credits", credits, full_cr);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_in_pop", in_pop, 0);

        // Credit exhaustion: output 1 VC0 from input 2.
        for (int k = 0; k < 8; k++) push(1, 0, 32'h0200_0000 + 32'(k));
        step();
        sel[1][0]    = SW'(2);
        in_empty[2]  = 1'b0;
        enable[1][0] = 1'b1;
        repeat (10) step();
        at_neg();
        check("exhaust_valid", out_valid[1], 0);
        check("exhaust_credits", credits[1][0], 0);
        check("exhaust_drained", exp_q.size(), 0);
        push(1, 0, 32'h0200_0008);
        step();
        credit_return[1][0] = 1'b1;
        step();
        credit_return[1][0] = 1'b0;
        repeat (5) step();
        at_neg();
        check("one_credit_credits", credits[1][0], 0);
        check("one_credit_valid", out_valid[1], 0);
        check("one_credit_drained", exp_q.size(), 0);
        enable[1][0] = 1'b0;
        in_empty     = '1;

        // Round-robin on output 0: VC0 <- input 0, VC1 <- input 1.
        push(0, 0, 32'h0000_0000);
        push(0, 1, 32'h0100_0000);
        push(0, 0, 32'h0000_0001);
        push(0, 1, 32'h0100_0001);
        step();
        sel[0][0]   = SW'(0);
        sel[0][1]   = SW'(1);
        in_empty[0] = 1'b0;
        in_empty[1] = 1'b0;
        enable[0]   = 2'b11;
        repeat (4) step();
        enable[0] = 2'b00;
        in_empty  = '1;
        repeat (3) step();
        at_neg();
        check("rr_credits_vc0", credits[0][0], 6);
        check("rr_credits_vc1", credits[0][1], 6);
        check("rr_drained", exp_q.size(), 0);

        // Backpressure on output 2 VC1 from input 3.
        push(2, 1, 32'h0300_0000);
        push(2, 1, 32'h0300_0001);
        step();
        out_ready[2] = 1'b0;
        sel[2][1]    = SW'(3);
        in_empty[3]  = 1'b0;
        enable[2][1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            at_neg();
            check("bp_flit_stable", out_flit[2], 32'h0300_0000);
            check("bp_valid", out_valid[2], 1);
            check("bp_no_pop", in_pop[3], 0);
        end
        step();
        out_ready[2] = 1'b1;
        step();
        enable[2][1] = 1'b0;
        at_neg();
        check("bp_next_flit", out_flit[2], 32'h0300_0001);
        in_empty = '1;
        repeat (2) step();

        // Conflict: outputs 1 and 3 both select input 4.
        push(1, 1, 32'h0400_0000);
        push(3, 0, 32'h0400_0001);
        sel[1][1]    = SW'(4);
        sel[3][0]    = SW'(4);
        in_empty[4]  = 1'b0;
        enable[1][1] = 1'b1;
        enable[3][0] = 1'b1;
        at_neg();
        check("conflict_single_pop", in_pop, 5'b10000);
        step();
        enable[1][1] = 1'b0;
        at_neg();
        check("conflict_winner", {out_valid[1], out_valid[3]}, 2'b10);
        step();
        enable[3][0] = 1'b0;
        at_neg();
        check("conflict_loser_next", out_valid[3], 1);
        check("conflict_loser_flit", out_flit[3], 32'h0400_0001);
        in_empty = '1;
        repeat (2) step();

        // Saturation on output 4 VC0.
        credit_return[4][0] = 1'b1;
        step();
        credit_return[4][0] = 1'b0;
        at_neg();
        check("sat_full", credits[4][0], 8);
        for (int k = 2; k < 7; k++) push(4, 0, 32'(k));
        step();
        sel[4][0]    = SW'(0);
        in_empty[0]  = 1'b0;
        enable[4][0] = 1'b1;
        repeat (5) step();
        enable[4][0] = 1'b0;
        at_neg();
        check("sat_at_three", credits[4][0], 3);
        push(4, 0, 32'h0000_0007);
        step();
        enable[4][0]        = 1'b1;
        credit_return[4][0] = 1'b1;
        step();
        enable[4][0]        = 1'b0;
        credit_return[4][0] = 1'b0;
        at_neg();
        check("sat_issue_and_return", credits[4][0], 3);
        in_empty = '1;
        repeat (2) step();

        // Held flit survives enable drop; reset discards it.
        out_ready[0] = 1'b0;
        sel[0][0]    = SW'(0);
        in_empty[0]  = 1'b0;
        enable[0][0] = 1'b1;
        step();
        enable[0][0] = 1'b0;
        repeat (2) step();
        at_neg();
        check("hold_after_disable_valid", out_valid[0], 1);
        check("hold_after_disable_flit", out_flit[0], 32'h0000_0008);
        enable[0][0] = 1'b1;
        #1 n_rst = 1'b0;
        #1;
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_flit", out_flit[0], 0);
        check("rst_hold_pop", in_pop, 0);
        check("rst_hold_credits", credits, full_cr);
        enable    = '0;
        in_empty  = '1;
        out_ready = '1;
        at_neg();
        n_rst = 1'b1;
        step();
        at_neg();
        check("rst_release_valid", out_valid, 0);
        repeat (2) step();
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
